count_mode_scheduler: RTL and testbench

COUNT_MODE_SCHEDULER -- requirements
Module: count_mode_scheduler

---
 rtl/count_sched_pkg.sv | 30 +++
 rtl/sched_cycle_timer.sv | 46 ++++
 rtl/count_mode_scheduler.sv | 151 +++++++++++++++
 tb/tb_count_mode_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// count_sched_pkg
//   Shared definitions for count_mode_scheduler and its phase timer:
//   default widths, the legacy state encoding constants and the FSM
//   state enumeration built on them.
//   Optional feature macro used by the top: SCHED_ABORT_EN.
package count_sched_pkg;

    localparam int unsigned CYC_W_DEF = 4;
    localparam int unsigned RND_W_DEF = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_RUN_BIN  = 3'd2;
    localparam logic [2:0] ST_RUN_GRAY = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_CLEAR    = ST_CLEAR,
        S_RUN_BIN  = ST_RUN_BIN,
        S_RUN_GRAY = ST_RUN_GRAY,
        S_FINISH   = ST_FINISH
    } sched_state_e;

    // States in which the schedule owns the counter (Busy high).
    function automatic logic is_active(input sched_state_e s);
        return (s == S_CLEAR) || (s == S_RUN_BIN) || (s == S_RUN_GRAY);
    endfunction

endpackage

// File: rtl/sched_cycle_timer.sv
// sched_cycle_timer
//   Down-counting phase timer. Loaded with (cycles-1) on phase entry,
//   decremented once per phase cycle; zero_o marks the last cycle of
//   the phase. Decrement stops at zero, so the count never wraps.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     load_i         load load_val_i (takes priority over dec_i)
//     load_val_i     value to load
//     dec_i          decrement request (ignored at zero)
//     zero_o         count is zero
module sched_cycle_timer
    import count_sched_pkg::*;
#(
    parameter int unsigned W = CYC_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/count_mode_scheduler.sv
// count_mode_scheduler
//   Sequences a 3-bit counter through a schedule: one CLEAR cycle, then
//   Rounds repetitions of BinCycles enabled cycles with Mode=0 followed
//   by GrayCycles enabled cycles with Mode=1, then a one-cycle Done.
//   Optional macro SCHED_ABORT_EN adds the Abort input.
//   Ports:
//     Clk, nReset           clock, asynchronous active-low reset
//     Start                 begin a schedule (sampled only in IDLE)
//     BinCycles/GrayCycles  enabled cycles per round in each mode
//     Rounds                number of Bin+Gray rounds
//     Abort                 (SCHED_ABORT_EN only) end schedule early
//     Mode, CntEnable, CntClear  counter controls
//     Busy, Done            schedule status
module count_mode_scheduler
    import count_sched_pkg::*;
#(
    parameter int unsigned CYC_W = CYC_W_DEF,
    parameter int unsigned RND_W = RND_W_DEF
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Start,
    input  logic [CYC_W-1:0] BinCycles,
    input  logic [CYC_W-1:0] GrayCycles,
    input  logic [RND_W-1:0] Rounds,
`ifdef SCHED_ABORT_EN
    input  logic             Abort,
`endif
    output logic             Mode,
    output logic             CntEnable,
    output logic             CntClear,
    output logic             Busy,
    output logic             Done
);

    sched_state_e     state_q, state_d;
    logic [CYC_W-1:0] bin_q, bin_d;
    logic [CYC_W-1:0] gray_q, gray_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             mode_q, en_q, clr_q, busy_q, done_q;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CYC_W-1:0] tmr_val;

    // First phase of every round: Bin unless Bin is empty.
    sched_state_e     first_state;
    logic [CYC_W-1:0] first_val;

    assign first_state = (bin_q != '0) ? S_RUN_BIN : S_RUN_GRAY;
    assign first_val   = (bin_q != '0) ? (bin_q - 1'b1) : (gray_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        gray_d   = gray_q;
        rnd_d    = rnd_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_CLEAR;
                    bin_d   = BinCycles;
                    gray_d  = GrayCycles;
                    rnd_d   = Rounds;
                end
            end
            S_CLEAR: begin
                if ((rnd_q == '0) || ((bin_q == '0) && (gray_q == '0))) begin
                    state_d = S_FINISH;
                end else begin
                    state_d  = first_state;
                    tmr_load = 1'b1;
                    tmr_val  = first_val;
                end
            end
            S_RUN_BIN, S_RUN_GRAY: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if ((state_q == S_RUN_BIN) && (gray_q != '0)) begin
                    state_d  = S_RUN_GRAY;
                    tmr_load = 1'b1;
                    tmr_val  = gray_q - 1'b1;
                end else begin
                    // End of round: restart the round directly, no CLEAR.
                    rnd_d = rnd_q - 1'b1;
                    if (rnd_q != RND_W'(1)) begin
                        state_d  = first_state;
                        tmr_load = 1'b1;
                        tmr_val  = first_val;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
`ifdef SCHED_ABORT_EN
        if (Abort && is_active(state_q)) begin
            state_d  = S_FINISH;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            rnd_q   <= rnd_d;
            mode_q  <= (state_d == S_RUN_GRAY);
            en_q    <= (state_d == S_RUN_BIN) || (state_d == S_RUN_GRAY);
            clr_q   <= (state_d == S_CLEAR);
            busy_q  <= is_active(state_d);
            done_q  <= (state_d == S_FINISH);
        end
    end

    sched_cycle_timer #(
        .W(CYC_W)
    ) u_timer (
        .clk_i      (Clk),
        .rst_ni     (nReset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign Mode      = mode_q;
    assign CntEnable = en_q;
    assign CntClear  = clr_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_count_mode_scheduler.sv
// tb_count_mode_scheduler
//   Bench for count_mode_scheduler. A schedule is modelled as a queue of
//   per-cycle output vectors {Mode,CntEnable,CntClear,Busy,Done} built
//   from the Bin/Gray/Rounds values seen at the accepting edge.
module tb_count_mode_scheduler;

    localparam int unsigned CYC_W = 4;
    localparam int unsigned RND_W = 3;

    localparam logic [4:0] E_IDLE = 5'b00000;
    localparam logic [4:0] E_CLR  = 5'b00110;
    localparam logic [4:0] E_BIN  = 5'b01010;
    localparam logic [4:0] E_GRAY = 5'b11010;
    localparam logic [4:0] E_FIN  = 5'b00001;

    logic             Clk = 1'b0;
    logic             nReset;
    logic             Start;
    logic [CYC_W-1:0] BinCycles;
    logic [CYC_W-1:0] GrayCycles;
    logic [RND_W-1:0] Rounds;
`ifdef SCHED_ABORT_EN
    logic             Abort;
`endif
    logic             Mode, CntEnable, CntClear, Busy, Done;
    logic [4:0]       obs;

    int checks = 0;
    int errors = 0;

    logic [4:0] expq[$];
    logic [4:0] exp_v = E_IDLE;

    count_mode_scheduler #(
        .CYC_W(CYC_W),
        .RND_W(RND_W)
    ) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Start      (Start),
        .BinCycles  (BinCycles),
        .GrayCycles (GrayCycles),
        .Rounds     (Rounds),
`ifdef SCHED_ABORT_EN
        .Abort      (Abort),
`endif
        .Mode       (Mode),
        .CntEnable  (CntEnable),
        .CntClear   (CntClear),
        .Busy       (Busy),
        .Done       (Done)
    );

    assign obs = {Mode, CntEnable, CntClear, Busy, Done};

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void plan(input int b, input int g, input int r);
        expq.push_back(E_CLR);
        if ((r != 0) && ((b != 0) || (g != 0))) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int i = 0; i < b; i++) expq.push_back(E_BIN);
                for (int i = 0; i < g; i++) expq.push_back(E_GRAY);
            end
        end
        expq.push_back(E_FIN);
        expq.push_back(E_IDLE);
    endfunction

    // Advance one clock: update the model from the inputs at the edge,
    // then compare the DUT outputs 1 ns later.
    task automatic tick();
        @(posedge Clk);
        if (!nReset) begin
            expq.delete();
            exp_v = E_IDLE;
        end
`ifdef SCHED_ABORT_EN
        else if (Abort && (exp_v[1] == 1'b1)) begin
            expq.delete();
            expq.push_back(E_IDLE);
            exp_v = E_FIN;
        end
`endif
        else if (expq.size() != 0) begin
            exp_v = expq.pop_front();
        end else if (Start) begin
            plan(int'(BinCycles), int'(GrayCycles), int'(Rounds));
            exp_v = expq.pop_front();
        end else begin
            exp_v = E_IDLE;
        end
        #1;
        check("cycle_outputs", 32'(obs), 32'(exp_v));
    endtask

    // Run one schedule from IDLE and tally what the DUT produced.
    task automatic measure(input int b, input int g, input int r, input bit perturb,
                           output int clr_n, output int en0_n, output int en1_n,
                           output int done_at, output logic [63:0] pat);
        clr_n = 0; en0_n = 0; en1_n = 0; done_at = -1; pat = '0;
        BinCycles  = CYC_W'(b);
        GrayCycles = CYC_W'(g);
        Rounds     = RND_W'(r);
        Start      = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 1) Start = 1'b0;
            if (perturb && (k == 2)) begin
                Start      = 1'b1;
                BinCycles  = ~BinCycles;
                GrayCycles = GrayCycles + 1'b1;
                Rounds     = Rounds + 1'b1;
            end
            if (perturb && (k == 3)) Start = 1'b0;
            if (CntClear) clr_n++;
            if (CntEnable) begin
                if (Mode) en1_n++; else en0_n++;
                pat = {pat[62:0], Mode};
            end
            if (Done) begin
                done_at = k;
                break;
            end
        end
        Start = 1'b0;
        tick();
    endtask

    int clr_n, en0_n, en1_n, done_at;
    logic [63:0] pat;
    bit found;

    initial begin
        nReset     = 1'b0;
        Start      = 1'b0;
        BinCycles  = '0;
        GrayCycles = '0;
        Rounds     = '0;
`ifdef SCHED_ABORT_EN
        Abort      = 1'b0;
`endif
        #1;
        check("reset_state", 32'(obs), 32'(E_IDLE));
        tick();
        #6;
        nReset = 1'b1;

        // Bin=5 Gray=7 Rounds=1, Start accepted on the first edge after reset.
        measure(5, 7, 1, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("r1_clear_cycles", 32'(clr_n), 32'd1);
        check("r1_bin_cycles", 32'(en0_n), 32'd5);
        check("r1_gray_cycles", 32'(en1_n), 32'd7);
        check("r1_total_cycles", 32'(done_at), 32'd14);

        // Bin=2 Gray=3 Rounds=3: back-to-back rounds, single clear.
        measure(2, 3, 3, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("r3_clear_cycles", 32'(clr_n), 32'd1);
        check("r3_enabled", 32'(en0_n + en1_n), 32'd15);
        check("r3_mode_pattern", pat[31:0], 32'b001110011100111);
        check("r3_total_cycles", 32'(done_at), 32'd17);

        // Bin=0: gray only.
        measure(0, 4, 2, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("b0_gray_cycles", 32'(en1_n), 32'd8);
        check("b0_bin_cycles", 32'(en0_n), 32'd0);
        check("b0_total_cycles", 32'(done_at), 32'd10);

        // Empty schedules: clear then immediate done.
        measure(0, 0, 3, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("empty_total_cycles", 32'(done_at), 32'd2);
        check("empty_clear", 32'(clr_n), 32'd1);
        measure(3, 2, 0, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("rounds0_total_cycles", 32'(done_at), 32'd2);
        check("rounds0_enabled", 32'(en0_n + en1_n), 32'd0);

        // Start and inputs changed mid-run have no effect.
        measure(4, 2, 2, 1'b1, clr_n, en0_n, en1_n, done_at, pat);
        check("perturb_bin_cycles", 32'(en0_n), 32'd8);
        check("perturb_gray_cycles", 32'(en1_n), 32'd4);
        check("perturb_total_cycles", 32'(done_at), 32'd14);

        // Asynchronous reset in RUN_GRAY.
        BinCycles = 4'd2; GrayCycles = 4'd5; Rounds = 3'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        check("pre_reset_in_gray", 32'(obs), 32'(E_GRAY));
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs), 32'd0);
        tick();
        tick();
        nReset = 1'b1;
        measure(2, 5, 1, 1'b0, clr_n, en0_n, en1_n, done_at, pat);
        check("post_reset_gray_cycles", 32'(en1_n), 32'd5);
        check("post_reset_total_cycles", 32'(done_at), 32'd9);

        // Start held high re-triggers after the IDLE cycle following FINISH.
        BinCycles = 4'd1; GrayCycles = 4'd1; Rounds = 3'd1; Start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (Done) begin found = 1'b1; break; end
        end
        check("hold_first_done", 32'(found), 32'd1);
        tick();
        check("hold_idle_gap", 32'(obs), 32'(E_IDLE));
        tick();
        check("hold_retrigger_clear", 32'(obs), 32'(E_CLR));
        Start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (Done) begin found = 1'b1; break; end
        end
        check("hold_second_done", 32'(found), 32'd1);
        tick();

`ifdef SCHED_ABORT_EN
        // Abort in the third RUN_BIN cycle of Bin=6.
        BinCycles = 4'd6; GrayCycles = 4'd2; Rounds = 3'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        check("abort_pre_state", 32'(obs), 32'(E_BIN));
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_enable_drop", 32'(CntEnable), 32'd0);
        check("abort_done", 32'(Done), 32'd1);
        tick();
        check("abort_idle_after", 32'(obs), 32'(E_IDLE));
        Abort = 1'b1;
        tick();
        check("abort_ignored_idle", 32'(obs), 32'(E_IDLE));
        Abort = 1'b0;
`endif

        // Randomized traffic checked every cycle by the model.
        for (int n = 0; n < 4000; n++) begin
            Start      = ($urandom_range(0, 5) == 0);
            BinCycles  = ($urandom_range(0, 9) == 0) ? 4'hF : CYC_W'($urandom_range(0, 5));
            GrayCycles = ($urandom_range(0, 9) == 0) ? 4'hF : CYC_W'($urandom_range(0, 5));
            Rounds     = RND_W'($urandom_range(0, 3));
`ifdef SCHED_ABORT_EN
            Abort      = ($urandom_range(0, 49) == 0);
`endif
            if ($urandom_range(0, 399) == 0) begin
                nReset = 1'b0;
                tick();
                tick();
                nReset = 1'b1;
            end
            tick();
        end

        Start = 1'b0;
`ifdef SCHED_ABORT_EN
        Abort = 1'b0;
`endif
        repeat (300) tick();
        check("final_idle", 32'(obs), 32'(E_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
